// File: rtl/issue_pkg.sv
// Shared types and widths for the instruction issue queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package issue_pkg;

    localparam int INSTR_W  = 16;
    localparam int ISSUED_W = 16;

    // Issue FSM: IDLE waits for work, WAIT holds an in-flight instruction,
    // ERR parks the queue after the datapath failed to answer in time.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

endpackage

// File: rtl/instr_issue_queue_if.sv
// Host/datapath bundle of the instruction issue queue.
// Latency: n/a (wires only).
// Backpressure: FULL tells the host its pushes are dropped; RDY paces issue.
//
// master : host / datapath side (drives WR_EN, WR_DATA, RUN, CLR_ERR, RDY)
// slave  : the queue itself (drives INSTR, START, status and ISSUED)
interface instr_issue_queue_if #(
    parameter int DEPTH = 8
);
    import issue_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                WR_EN;
    logic [INSTR_W-1:0]  WR_DATA;
    logic                RUN;
    logic                CLR_ERR;
    logic                RDY;
    logic [INSTR_W-1:0]  INSTR;
    logic                START;
    logic                FULL;
    logic                EMPTY;
    logic [CNT_W-1:0]    COUNT;
    logic                BUSY;
    logic                TIMEOUT_ERR;
    logic [ISSUED_W-1:0] ISSUED;

    modport master (
        output WR_EN, WR_DATA, RUN, CLR_ERR, RDY,
        input  INSTR, START, FULL, EMPTY, COUNT, BUSY, TIMEOUT_ERR, ISSUED
    );

    modport slave (
        input  WR_EN, WR_DATA, RUN, CLR_ERR, RDY,
        output INSTR, START, FULL, EMPTY, COUNT, BUSY, TIMEOUT_ERR, ISSUED
    );

endinterface

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with occupancy count.
// Latency: push visible at the head one cycle after the write edge; head read is combinational.
// Backpressure: push while full and pop while empty are ignored.
//
// Ports: clk/rst (sync, active-high), push/push_data, pop/pop_data (head),
//        full, empty, count. Flags come straight from the registered pointers.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    // One extra pointer bit separates "full" from "empty" when the
    // index bits match.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push;
    logic        do_pop;

    always_comb begin
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty    = (wr_ptr_q == rd_ptr_q);
        count    = wr_ptr_q - rd_ptr_q;
        pop_data = mem[rd_ptr_q[AW-1:0]];

        do_push  = push && !full;
        do_pop   = pop && !empty;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage has no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/instr_issue_queue.sv
// Buffers host instructions and issues them one at a time over a START/RDY handshake.
// Latency: RUN with a non-empty FIFO at edge t gives START and INSTR in cycle t+1; min START period 2.
// Backpressure: host pushes dropped while FULL; next issue waits for RDY; no RDY for TIMEOUT cycles parks in ERR.
//
// Ports: CLK, RST (sync, active-high); io (slave modport) carrying the host
//        push side, RUN/CLR_ERR controls, the RDY/START/INSTR handshake,
//        FIFO status, BUSY, sticky TIMEOUT_ERR and the ISSUED counter.
module instr_issue_queue
    import issue_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                  CLK,
    input  logic                  RST,
    instr_issue_queue_if.slave    io
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int TMR_W = 16;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t              state_q,  state_d;
    logic [INSTR_W-1:0]  instr_q,  instr_d;
    logic                start_q,  start_d;
    logic                err_q,    err_d;
    logic [TMR_W-1:0]    timer_q,  timer_d;
    logic [ISSUED_W-1:0] issued_q, issued_d;

    logic                fifo_pop;
    logic [INSTR_W-1:0]  fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;

    sync_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (io.WR_EN),
        .push_data (io.WR_DATA),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        start_d  = 1'b0;       // START is a single-cycle pulse
        err_d    = err_q;
        timer_d  = timer_q;
        issued_d = issued_q;
        fifo_pop = 1'b0;

        case (state_q)
            IDLE: begin
                if (io.RUN && !fifo_empty) begin
                    instr_d  = fifo_head;
                    start_d  = 1'b1;
                    fifo_pop = 1'b1;
                    timer_d  = '0;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                // RDY in the START cycle already counts as completion.
                if (io.RDY) begin
                    issued_d = issued_q + ISSUED_W'(1);
                    state_d  = IDLE;
                end else if (timer_q == TMR_LAST) begin
                    // The in-flight instruction is abandoned, not requeued.
                    err_d   = 1'b1;
                    state_d = ERR;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ERR: begin
                if (io.CLR_ERR) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            instr_q  <= '0;
            start_q  <= 1'b0;
            err_q    <= 1'b0;
            timer_q  <= '0;
            issued_q <= '0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            start_q  <= start_d;
            err_q    <= err_d;
            timer_q  <= timer_d;
            issued_q <= issued_d;
        end
    end

    assign io.INSTR       = instr_q;
    assign io.START       = start_q;
    assign io.FULL        = fifo_full;
    assign io.EMPTY       = fifo_empty;
    assign io.COUNT       = fifo_count;
    assign io.BUSY        = (state_q == WAIT);
    assign io.TIMEOUT_ERR = err_q;
    assign io.ISSUED      = issued_q;

endmodule

// File: tb/tb_instr_issue_queue.sv
// Bench for instr_issue_queue: directed scenarios then random traffic,
// every cycle compared against a queue-based reference model.
module tb_instr_issue_queue;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_issue_queue_if #(.DEPTH(DEPTH)) io ();

    instr_issue_queue #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .io  (io)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: a word queue plus "in flight / parked" flags.
    logic [15:0] m_q[$];
    logic        m_busy;
    logic        m_err;
    logic        m_start;
    logic [15:0] m_instr;
    logic [15:0] m_issued;
    int          m_waited;

    // Observations of the DUT used by the directed checks.
    int          step_no = 0;
    int          obs_starts;
    logic [15:0] obs_log[$];
    int          start_steps[$];
    int          first_err_step;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic wr, input logic [15:0] wd, input logic run,
                              input logic clr, input logic rdy, input logic rst_i);
        int pre;
        pre = m_q.size();
        if (rst_i) begin
            m_q.delete();
            m_busy = 0; m_err = 0; m_start = 0;
            m_instr = '0; m_issued = '0; m_waited = 0;
        end else begin
            m_start = 0;
            if (m_err) begin
                if (clr) m_err = 0;
            end else if (m_busy) begin
                if (rdy) begin
                    m_issued = m_issued + 16'd1;
                    m_busy   = 0;
                end else begin
                    m_waited++;
                    if (m_waited == TIMEOUT) begin
                        m_busy = 0;
                        m_err  = 1;
                    end
                end
            end else if (run && pre > 0) begin
                m_instr  = m_q.pop_front();
                m_start  = 1;
                m_busy   = 1;
                m_waited = 0;
            end
            if (wr && pre < DEPTH) m_q.push_back(wd);
        end
    endtask

    function automatic logic auto_rdy();
        return m_busy && (m_waited == 3);
    endfunction

    task automatic step(input logic wr, input logic [15:0] wd, input logic run,
                        input logic clr, input logic rdy, input logic rst_i);
        @(negedge clk);
        io.WR_EN   = wr;
        io.WR_DATA = wd;
        io.RUN     = run;
        io.CLR_ERR = clr;
        io.RDY     = rdy;
        rst        = rst_i;
        @(posedge clk);
        model_edge(wr, wd, run, clr, rdy, rst_i);
        #1;
        step_no++;
        if (io.START === 1'b1) begin
            obs_starts++;
            obs_log.push_back(io.INSTR);
            start_steps.push_back(step_no);
        end
        if (io.TIMEOUT_ERR === 1'b1 && first_err_step < 0) first_err_step = step_no;
        check("START", io.START, m_start);
        check("INSTR", io.INSTR, m_instr);
        check("COUNT", io.COUNT, m_q.size());
        check("FULL", io.FULL, m_q.size() == DEPTH);
        check("EMPTY", io.EMPTY, m_q.size() == 0);
        check("BUSY", io.BUSY, m_busy);
        check("TIMEOUT_ERR", io.TIMEOUT_ERR, m_err);
        check("ISSUED", io.ISSUED, m_issued);
    endtask

    task automatic clear_obs();
        obs_starts = 0;
        obs_log.delete();
        start_steps.delete();
        first_err_step = -1;
    endtask

    initial begin
        io.WR_EN = 0; io.WR_DATA = '0; io.RUN = 0; io.CLR_ERR = 0; io.RDY = 0;
        rst = 1;
        clear_obs();

        // Reset values
        step(0, 16'h0, 0, 0, 0, 1);
        step(0, 16'h0, 0, 0, 0, 1);
        check("rst_count", io.COUNT, 0);
        check("rst_empty", io.EMPTY, 1);
        check("rst_full", io.FULL, 0);
        check("rst_start", io.START, 0);
        check("rst_instr", io.INSTR, 0);
        check("rst_busy", io.BUSY, 0);
        check("rst_err", io.TIMEOUT_ERR, 0);
        check("rst_issued", io.ISSUED, 0);

        // Two words, datapath answers 3 cycles after each START
        clear_obs();
        step(1, 16'h1234, 1, 0, auto_rdy(), 0);
        step(1, 16'h5678, 1, 0, auto_rdy(), 0);
        repeat (12) step(0, 16'h0, 1, 0, auto_rdy(), 0);
        check("t1_starts", obs_starts, 2);
        check("t1_instr0", obs_log.size() > 0 ? obs_log[0] : 16'hxxxx, 16'h1234);
        check("t1_instr1", obs_log.size() > 1 ? obs_log[1] : 16'hxxxx, 16'h5678);
        check("t1_issued", io.ISSUED, 2);
        check("t1_empty", io.EMPTY, 1);

        // Nine pushes into an eight-deep FIFO
        for (int i = 0; i < 9; i++) begin
            step(1, 16'(16'hA000 + i), 0, 0, 0, 0);
            if (i == 7) check("t2_full_at_8", io.FULL, 1);
        end
        check("t2_full", io.FULL, 1);
        check("t2_count", io.COUNT, 8);
        clear_obs();
        repeat (20) step(0, 16'h0, 1, 0, 1, 0);
        check("t2_drained", obs_starts, 8);
        check("t2_last", obs_log.size() == 8 ? obs_log[7] : 16'hxxxx, 16'hA007);
        check("t2_issued", io.ISSUED, 10);

        // RDY held high: back-to-back issue every 2 cycles
        step(0, 16'h0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 16'(16'hC000 + i), 0, 0, 0, 0);
        clear_obs();
        repeat (8) step(0, 16'h0, 1, 0, 1, 0);
        check("t3_starts", obs_starts, 4);
        for (int k = 0; k < 3; k++)
            check("t3_period", (start_steps.size() > k + 1) ? start_steps[k+1] - start_steps[k] : -1, 2);
        check("t3_issued", io.ISSUED, 4);

        // Timeout with no RDY, then CLR_ERR resumes the remaining words
        for (int i = 0; i < 3; i++) step(1, 16'(16'hD000 + i), 0, 0, 0, 0);
        clear_obs();
        repeat (10) step(0, 16'h0, 1, 0, 0, 0);
        check("t4_err_delay", (start_steps.size() > 0) ? first_err_step - start_steps[0] : -1, TIMEOUT);
        check("t4_one_start", obs_starts, 1);
        check("t4_err", io.TIMEOUT_ERR, 1);
        check("t4_count_kept", io.COUNT, 2);
        step(0, 16'h0, 1, 1, 0, 0);
        check("t4_cleared", io.TIMEOUT_ERR, 0);
        repeat (15) step(0, 16'h0, 1, 0, auto_rdy(), 0);
        check("t4_resumed", obs_starts, 3);
        check("t4_last", obs_log.size() == 3 ? obs_log[2] : 16'hxxxx, 16'hD002);
        check("t4_issued", io.ISSUED, 6);

        // Reset in the second WAIT cycle, late RDY ignored
        step(0, 16'h0, 0, 0, 0, 1);
        step(1, 16'hE000, 0, 0, 0, 0);
        step(1, 16'hE001, 0, 0, 0, 0);
        step(0, 16'h0, 1, 0, 0, 0);
        check("t5_started", io.START, 1);
        step(0, 16'h0, 1, 0, 0, 1);
        check("t5_start", io.START, 0);
        check("t5_count", io.COUNT, 0);
        check("t5_busy", io.BUSY, 0);
        step(0, 16'h0, 0, 0, 1, 0);
        check("t5_issued", io.ISSUED, 0);

        // Push coinciding with an issue pop at COUNT=3
        step(0, 16'h0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 16'(16'hB000 + i), 0, 0, 0, 0);
        check("t6_pre", io.COUNT, 3);
        clear_obs();
        step(1, 16'hB003, 1, 0, 0, 0);
        check("t6_count", io.COUNT, 3);
        check("t6_instr", io.INSTR, 16'hB000);
        repeat (12) step(0, 16'h0, 1, 0, 1, 0);
        check("t6_starts", obs_starts, 4);
        for (int k = 0; k < 4; k++)
            check("t6_order", (obs_log.size() > k) ? obs_log[k] : 16'hxxxx, 16'(16'hB000 + k));

        // Random traffic against the model
        step(0, 16'h0, 0, 0, 0, 1);
        for (int n = 0; n < 500; n++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom), ($urandom % 4) != 0,
                 ($urandom % 8) == 0, ($urandom % 3) == 0, ($urandom % 64) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
